// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache_mem_ctrl byte-addressable memory.
package cache_mem_pkg;

  localparam logic [1:0] SIZE_NONE = 2'd0;
  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;
  localparam logic [1:0] SIZE_WORD = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [2:0] sizeBytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // Lane mask covering the lowest 'count' byte lanes of a word.
  function automatic logic [3:0] lowLanes(input logic [2:0] count);
    case (count)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Expand a 4-bit lane mask into a 32-bit bit mask.
  function automatic logic [31:0] laneBits(input logic [3:0] lanes);
    logic [31:0] bits;
    for (int b = 0; b < 4; b++) begin
      bits[8*b +: 8] = {8{lanes[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/cache_mem_lane_align.sv
// Big-endian lane steering for cache_mem_ctrl: byte enables, write-data
// placement and read-data extraction/merge for the first or second word of
// an access. Byte offset 0 is the most significant lane (bits 31:24).
module cache_mem_lane_align
  import cache_mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_phase,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_rpart,
  output logic        o_crossing,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlane,
  output logic [31:0] o_rdata
);

  logic [2:0] w_bytes;
  logic [2:0] w_end;
  logic [2:0] w_gap;
  logic [2:0] w_first;
  logic [2:0] w_rest;
  logic [2:0] w_restGap;

  assign w_bytes    = sizeBytes(i_size);
  assign w_end      = {1'b0, i_offset} + w_bytes;
  assign o_crossing = (w_end > 3'd4);
  assign w_gap      = 3'd4 - w_end;
  assign w_first    = 3'd4 - {1'b0, i_offset};
  assign w_rest     = w_end - 3'd4;
  assign w_restGap  = 3'd4 - w_rest;

  // Steer lanes: second word holds the low data bytes in its top lanes,
  // first word of a crossing holds the high data bytes in its bottom lanes.
  always_comb begin
    o_be    = 4'b0000;
    o_wlane = 32'h0;
    o_rdata = 32'h0;
    if (i_phase) begin
      o_be    = lowLanes(w_rest) << w_restGap;
      o_wlane = i_wdata << {w_restGap, 3'b000};
      o_rdata = (i_rpart << {w_rest, 3'b000}) | (i_rword >> {w_restGap, 3'b000});
    end else if (o_crossing) begin
      o_be    = lowLanes(w_first);
      o_wlane = i_wdata >> {w_rest, 3'b000};
      o_rdata = i_rword & laneBits(lowLanes(w_first));
    end else begin
      o_be    = lowLanes(w_bytes) << w_gap;
      o_wlane = i_wdata << {w_gap, 3'b000};
      o_rdata = (i_rword >> {w_gap, 3'b000}) & laneBits(lowLanes(w_bytes));
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Byte-addressable big-endian memory with valid/ready request port and a
// registered one-cycle response. Accesses straddling a word boundary are
// split over two cycles when CACHE_MEM_UNALIGNED_EN is defined, otherwise
// they are answered with an error.
module cache_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 6144
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int                WORDS     = DEPTH_BYTES / 4;
  localparam int                MEM_IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W:0]   LP_DEPTH  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   LP_ONE    = (ADDR_W+1)'(1);

  logic [31:0]          r_mem [WORDS];
  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_pendOffset;
  logic [1:0]           r_pendSize;
  logic                 r_pendWe;
  logic [31:0]          r_pendWdata;
  logic [MEM_IDX_W-1:0] r_pendIdx;
  logic [31:0]          r_part;
  logic                 r_rspValid;
  logic                 r_rspErr;
  logic [31:0]          r_rspRdata;

  logic                 w_accept;
  logic                 w_inSplit;
  logic [2:0]           w_bytes;
  logic [ADDR_W:0]      w_lastAddr;
  logic                 w_rangeErr;
  logic                 w_err;
  logic                 w_crossing;
  logic                 w_startSplit;
  logic                 w_memWe;
  logic [MEM_IDX_W-1:0] w_reqIdx;
  logic [MEM_IDX_W-1:0] w_memIdx;
  logic [1:0]           w_offset;
  logic [1:0]           w_size;
  logic [31:0]          w_wdata;
  logic [31:0]          w_rword;
  logic [3:0]           w_be;
  logic [31:0]          w_wlane;
  logic [31:0]          w_rdata;

  assign w_accept   = i_req_valid && o_req_ready;
  assign w_inSplit  = (r_state == SPLIT);
  assign w_bytes    = sizeBytes(i_req_size);
  assign w_lastAddr = {1'b0, i_req_addr} + {{(ADDR_W-2){1'b0}}, w_bytes} - LP_ONE;
  assign w_rangeErr = (w_bytes != 3'd0) && (w_lastAddr >= LP_DEPTH);

`ifdef CACHE_MEM_UNALIGNED_EN
  assign w_err        = w_rangeErr;
  assign w_startSplit = w_accept && w_crossing && !w_err;
`else
  assign w_err        = w_rangeErr || w_crossing;
  assign w_startSplit = 1'b0;
`endif

  assign w_reqIdx = i_req_addr[MEM_IDX_W+1:2];
  assign w_memIdx = w_inSplit ? (r_pendIdx + MEM_IDX_W'(1)) : (w_err ? '0 : w_reqIdx);
  assign w_offset = w_inSplit ? r_pendOffset : i_req_addr[1:0];
  assign w_size   = w_inSplit ? r_pendSize : i_req_size;
  assign w_wdata  = w_inSplit ? r_pendWdata : i_req_wdata;
  assign w_rword  = r_mem[w_memIdx];
  assign w_memWe  = w_inSplit ? r_pendWe : (w_accept && i_req_we && !w_err);

  cache_mem_lane_align u_laneAlign (
    .i_offset   (w_offset),
    .i_size     (w_size),
    .i_phase    (w_inSplit),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .i_rpart    (r_part),
    .o_crossing (w_crossing),
    .o_be       (w_be),
    .o_wlane    (w_wlane),
    .o_rdata    (w_rdata)
  );

  // Byte-lane writes into the storage array; contents survive reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_memWe && w_be[b]) begin
        r_mem[w_memIdx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: a legal crossing spends one extra cycle in SPLIT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startSplit) w_nextState = SPLIT;
      SPLIT:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: ready depends on state only.
  always_comb begin
    o_req_ready = (r_state == IDLE);
  end

  // Response registers and the context held across the split cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rspValid   <= 1'b0;
      r_rspErr     <= 1'b0;
      r_rspRdata   <= 32'h0;
      r_part       <= 32'h0;
      r_pendOffset <= 2'd0;
      r_pendSize   <= SIZE_NONE;
      r_pendWe     <= 1'b0;
      r_pendWdata  <= 32'h0;
      r_pendIdx    <= '0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= 32'h0;
      if (w_inSplit) begin
        r_rspValid <= 1'b1;
        r_rspRdata <= r_pendWe ? 32'h0 : w_rdata;
      end else if (w_startSplit) begin
        r_part       <= w_rdata;
        r_pendOffset <= i_req_addr[1:0];
        r_pendSize   <= i_req_size;
        r_pendWe     <= i_req_we;
        r_pendWdata  <= i_req_wdata;
        r_pendIdx    <= w_reqIdx;
      end else if (w_accept) begin
        r_rspValid <= 1'b1;
        r_rspErr   <= w_err;
        r_rspRdata <= (w_err || i_req_we) ? 32'h0 : w_rdata;
      end
    end
  end

  assign o_rsp_valid = r_rspValid;
  assign o_rsp_err   = r_rspErr;
  assign o_rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed self-checking bench for cache_mem_ctrl. Expectations follow the
// CACHE_MEM_UNALIGNED_EN setting used for the build.
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'd0;
  logic [15:0] reqAddr = 16'h0;
  logic [31:0] reqWdata = 32'h0;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;

  int compareCount = 0;
  int mismatchCount = 0;

`ifdef CACHE_MEM_UNALIGNED_EN
  localparam logic [31:0] EXP_WORD4 = 32'h0000DEAD;
  localparam logic [31:0] EXP_WORD8 = 32'hBEEF3344;
`else
  localparam logic [31:0] EXP_WORD4 = 32'h00000000;
  localparam logic [31:0] EXP_WORD8 = 32'h11223344;
`endif

  always #5 clk = ~clk;

  cache_mem_ctrl #(.ADDR_W(16), .DEPTH_BYTES(6144)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_we    (reqWe),
    .i_req_size  (reqSize),
    .i_req_addr  (reqAddr),
    .i_req_wdata (reqWdata),
    .o_rsp_valid (rspValid),
    .o_rsp_rdata (rspRdata),
    .o_rsp_err   (rspErr)
  );

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request starting at a falling edge and wait a bounded time for its response.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [15:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                               output int latency, output logic readyAfter);
    reqValid = 1'b1;
    reqWe    = we;
    reqSize  = size;
    reqAddr  = addr;
    reqWdata = wdata;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqSize  = 2'd0;
    reqAddr  = 16'h0;
    reqWdata = 32'h0;
    latency    = 0;
    rdata      = 32'h0;
    err        = 1'b0;
    readyAfter = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) readyAfter = reqReady;
      if (rspValid) begin
        latency = c;
        rdata   = rspRdata;
        err     = rspErr;
        break;
      end
    end
  endtask

  task automatic doAccess(input string tag, input logic we, input logic [1:0] size, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expData, input logic expErr, input int expLat);
    logic [31:0] rdata;
    logic        err;
    int          latency;
    logic        readyAfter;
    applyStimulus(we, size, addr, wdata, rdata, err, latency, readyAfter);
    checkOutput({tag, " latency"}, latency, expLat);
    checkOutput({tag, " data"}, rdata, expData);
    checkOutput({tag, " err"}, {31'h0, err}, {31'h0, expErr});
    checkOutput({tag, " ready"}, {31'h0, readyAfter}, {31'h0, (expLat == 1)});
  endtask

  task automatic quietWrite(input logic [1:0] size, input logic [15:0] addr, input logic [31:0] wdata);
    logic [31:0] rdata;
    logic        err;
    int          latency;
    logic        readyAfter;
    applyStimulus(1'b1, size, addr, wdata, rdata, err, latency, readyAfter);
  endtask

  initial begin
    #100000;
    mismatchCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expWords [4];
    expWords[0] = 32'hCAFEF00D;
    expWords[1] = EXP_WORD4;
    expWords[2] = EXP_WORD8;
    expWords[3] = 32'h01020304;

    repeat (2) @(negedge clk);
    checkOutput("reset ready", {31'h0, reqReady}, 32'h1);
    checkOutput("reset valid", {31'h0, rspValid}, 32'h0);
    checkOutput("reset rdata", rspRdata, 32'h0);
    checkOutput("reset err", {31'h0, rspErr}, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 24; a += 4) quietWrite(2'd3, 16'(a), 32'h0);
    quietWrite(2'd3, 16'h0000, 32'hCAFEF00D);
    quietWrite(2'd3, 16'h000C, 32'h01020304);

    $display("[TB] aligned and misaligned non-crossing accesses");
    doAccess("wr word 0008", 1'b1, 2'd3, 16'h0008, 32'h11223344, 32'h0, 1'b0, 1);
    doAccess("rd byte 0009", 1'b0, 2'd1, 16'h0009, 32'h0, 32'h00000022, 1'b0, 1);
    doAccess("rd byte 0008", 1'b0, 2'd1, 16'h0008, 32'h0, 32'h00000011, 1'b0, 1);
    doAccess("rd half 000A", 1'b0, 2'd2, 16'h000A, 32'h0, 32'h00003344, 1'b0, 1);
    doAccess("wr half 0011", 1'b1, 2'd2, 16'h0011, 32'h0000ABCD, 32'h0, 1'b0, 1);
    doAccess("rd word 0010", 1'b0, 2'd3, 16'h0010, 32'h0, 32'h00ABCD00, 1'b0, 1);
    doAccess("rd half 0011", 1'b0, 2'd2, 16'h0011, 32'h0, 32'h0000ABCD, 1'b0, 1);

    $display("[TB] word-crossing accesses");
`ifdef CACHE_MEM_UNALIGNED_EN
    doAccess("wr word 0006", 1'b1, 2'd3, 16'h0006, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    doAccess("rd word 0006", 1'b0, 2'd3, 16'h0006, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    doAccess("rd half 000B", 1'b0, 2'd2, 16'h000B, 32'h0, 32'h00004401, 1'b0, 2);
    doAccess("rd half 0009", 1'b0, 2'd2, 16'h0009, 32'h0, 32'h0000EF33, 1'b0, 1);
`else
    doAccess("wr word 0006", 1'b1, 2'd3, 16'h0006, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    doAccess("rd word 0006", 1'b0, 2'd3, 16'h0006, 32'h0, 32'h0, 1'b1, 1);
    doAccess("rd half 000B", 1'b0, 2'd2, 16'h000B, 32'h0, 32'h0, 1'b1, 1);
    doAccess("rd half 0009", 1'b0, 2'd2, 16'h0009, 32'h0, 32'h00002233, 1'b0, 1);
`endif
    doAccess("rd word 0004", 1'b0, 2'd3, 16'h0004, 32'h0, EXP_WORD4, 1'b0, 1);
    doAccess("rd word 0008", 1'b0, 2'd3, 16'h0008, 32'h0, EXP_WORD8, 1'b0, 1);

    $display("[TB] range boundary and size zero");
    doAccess("rd word 17FE", 1'b0, 2'd3, 16'h17FE, 32'h0, 32'h0, 1'b1, 1);
    doAccess("wr byte FFFF", 1'b1, 2'd1, 16'hFFFF, 32'h0000005A, 32'h0, 1'b1, 1);
    doAccess("rd word FFFE", 1'b0, 2'd3, 16'hFFFE, 32'h0, 32'h0, 1'b1, 1);
    doAccess("rd byte 1800", 1'b0, 2'd1, 16'h1800, 32'h0, 32'h0, 1'b1, 1);
    doAccess("wr word 17FC", 1'b1, 2'd3, 16'h17FC, 32'h1234565A, 32'h0, 1'b0, 1);
    doAccess("rd word 17FC", 1'b0, 2'd3, 16'h17FC, 32'h0, 32'h1234565A, 1'b0, 1);
    doAccess("rd byte 17FF", 1'b0, 2'd1, 16'h17FF, 32'h0, 32'h0000005A, 1'b0, 1);
    doAccess("rd size0 0008", 1'b0, 2'd0, 16'h0008, 32'h0, 32'h0, 1'b0, 1);
    doAccess("wr size0 0008", 1'b1, 2'd0, 16'h0008, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
    doAccess("rd after size0", 1'b0, 2'd3, 16'h0008, 32'h0, EXP_WORD8, 1'b0, 1);

    $display("[TB] back-to-back reads");
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("b2b valid %0d", i - 1), {31'h0, rspValid}, 32'h1);
        checkOutput($sformatf("b2b data %0d", i - 1), rspRdata, expWords[i-1]);
      end
      if (i < 4) begin
        checkOutput($sformatf("b2b ready %0d", i), {31'h0, reqReady}, 32'h1);
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqSize  = 2'd3;
        reqAddr  = 16'(4 * i);
        @(negedge clk);
      end else begin
        reqValid = 1'b0;
      end
    end

    $display("[TB] write then read back-to-back");
    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'd3; reqAddr = 16'h0014; reqWdata = 32'h0C0FFEE0;
    @(negedge clk);
    checkOutput("wr-rd write valid", {31'h0, rspValid}, 32'h1);
    reqWe = 1'b0; reqWdata = 32'h0;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("wr-rd read valid", {31'h0, rspValid}, 32'h1);
    checkOutput("wr-rd read data", rspRdata, 32'h0C0FFEE0);
    @(negedge clk);

    $display("[TB] reset during a transaction");
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'd3;
`ifdef CACHE_MEM_UNALIGNED_EN
    reqAddr = 16'h0006;
`else
    reqAddr = 16'h0008;
`endif
    @(posedge clk);
    #2;
    rstN = 1'b0;
    reqValid = 1'b0;
    #1;
    checkOutput("mid reset valid", {31'h0, rspValid}, 32'h0);
    checkOutput("mid reset rdata", rspRdata, 32'h0);
    checkOutput("mid reset err", {31'h0, rspErr}, 32'h0);
    checkOutput("mid reset ready", {31'h0, reqReady}, 32'h1);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("post reset valid", {31'h0, rspValid}, 32'h0);
    doAccess("post reset rd byte 0009", 1'b0, 2'd1, 16'h0009, 32'h0, {24'h0, EXP_WORD8[23:16]}, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
